// File: rtl/aes_rx_if.sv
`timescale 1ns/1ps
// Byte-link receive bundle: transmitter-side inputs, FIFO-side status and the
// assembled-block outputs of the AES receive deserializer.
interface aes_rx_if;
    logic         en;
    logic [7:0]   rx;
    logic         shakehand;
    logic         full;
    logic [127:0] data;
    logic         push;
    logic         overflow;
    logic         timeout_err;

    modport master (
        output en, rx, shakehand, full,
        input  data, push, overflow, timeout_err
    );

    modport slave (
        input  en, rx, shakehand, full,
        output data, push, overflow, timeout_err
    );
endinterface

// File: rtl/aes_rx.sv
`timescale 1ns/1ps
// AES block receiver: synchronises a toggling byte strobe, collects 16 bytes
// MSB-first into a 128-bit block and hands each block to a downstream FIFO.
module aes_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic    clk,
    input  logic    rst_n,
    aes_rx_if.slave bus
);
    // Each sync stage carries {shakehand, rx} so both paths see identical delay.
    localparam int         CW        = 9;
    localparam int         TOP       = (SYNC_STAGES + 1) * CW - 1;
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    logic [SYNC_STAGES*CW-1:0] chain_r;
    logic [TOP:0]              chain_ext_s;
    logic                      sh_s;
    logic [7:0]                rx_s;
    logic                      sh_p_r;
    logic                      edge_s;

    logic [119:0] shift_r;
    logic [3:0]   index_r;
    logic [7:0]   idle_r;
    logic [127:0] data_r;
    logic         push_r;
    logic         overflow_r;
    logic         timeout_r;

    assign chain_ext_s = {chain_r, bus.shakehand, bus.rx};
    assign sh_s        = chain_ext_s[TOP];
    assign rx_s        = chain_ext_s[TOP-1 -: 8];
    assign edge_s      = sh_s ^ sh_p_r;

    // Input synchroniser; strobe resets to the link idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_r <= {SYNC_STAGES{9'h100}};
            sh_p_r  <= 1'b1;
        end else begin
            chain_r <= chain_ext_s[SYNC_STAGES*CW-1:0];
            sh_p_r  <= sh_s;
        end
    end

    // Byte assembly, idle timeout and registered FIFO-side pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r    <= 120'd0;
            index_r    <= 4'd0;
            idle_r     <= 8'd0;
            data_r     <= 128'd0;
            push_r     <= 1'b0;
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            push_r     <= 1'b0;
            overflow_r <= 1'b0;
            timeout_r  <= 1'b0;
            if (!bus.en) begin
                index_r <= 4'd0;
                idle_r  <= 8'd0;
            end else if (edge_s) begin
                // A strobe edge always wins over an expiring idle count.
                shift_r <= {shift_r[111:0], rx_s};
                index_r <= index_r + 4'd1;
                idle_r  <= 8'd0;
                if (index_r == 4'd15) begin
                    if (bus.full) begin
                        overflow_r <= 1'b1;
                    end else begin
                        push_r <= 1'b1;
                        data_r <= {shift_r, rx_s};
                    end
                end
            end else if (index_r != 4'd0) begin
                if (idle_r == IDLE_LAST) begin
                    index_r   <= 4'd0;
                    idle_r    <= 8'd0;
                    timeout_r <= 1'b1;
                end else begin
                    idle_r <= idle_r + 8'd1;
                end
            end else begin
                idle_r <= 8'd0;
            end
        end
    end

    assign bus.data        = data_r;
    assign bus.push        = push_r;
    assign bus.overflow    = overflow_r;
    assign bus.timeout_err = timeout_r;
endmodule

// File: tb/tb_aes_rx.sv
`timescale 1ns/1ps
// Bench for aes_rx: random byte traffic against a timestamped event model
// (captures, block completion, overflow and idle timeout).
module tb_aes_rx;
    localparam int SS  = 2;
    localparam int TMO = 64;
    localparam int LAT = SS + 1;

    typedef struct {
        int           kind;
        int           st;
        logic [127:0] d;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    ev_t          exp_q[$];
    ev_t          obs_q[$];
    logic [7:0]   mq[$];
    int           m_last = 0;
    logic [127:0] m_data = 128'd0;

    always #5 clk = ~clk;

    aes_rx_if bus();

    aes_rx #(.SYNC_STAGES(SS), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input int kind, input int st, input logic [127:0] d);
        ev_t e;
        e.kind = kind;
        e.st   = st;
        e.d    = d;
        return e;
    endfunction

    // Monitor: kind 0 = push, 1 = overflow, 2 = timeout_err.
    always @(negedge clk) begin
        if (bus.push === 1'b1)        obs_q.push_back(mk_ev(0, cyc, bus.data));
        if (bus.overflow === 1'b1)    obs_q.push_back(mk_ev(1, cyc, 128'd0));
        if (bus.timeout_err === 1'b1) obs_q.push_back(mk_ev(2, cyc, 128'd0));
    end

    // Reference model: a byte captured at stamp st with FIFO status f.
    task automatic model_capture(input int st, input logic [7:0] b, input logic f);
        logic [127:0] blk;
        if (mq.size() > 0 && st - m_last > TMO) begin
            exp_q.push_back(mk_ev(2, m_last + TMO, 128'd0));
            mq.delete();
        end
        mq.push_back(b);
        m_last = st;
        if (mq.size() == 16) begin
            blk = 128'd0;
            for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = mq[i];
            if (f) begin
                exp_q.push_back(mk_ev(1, st, 128'd0));
            end else begin
                exp_q.push_back(mk_ev(0, st, blk));
                m_data = blk;
            end
            mq.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        bus.rx        = b;
        bus.shakehand = ~bus.shakehand;
        model_capture(cyc + LAT, b, bus.full);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic send_block(input logic [127:0] blk, input int gmin, input int gmax, input logic f);
        bus.full = f;
        for (int i = 0; i < 16; i++) send_byte(blk[127-8*i -: 8], $urandom_range(gmax, gmin));
        idle(LAT + 2);
        bus.full = 1'b0;
    endtask

    function automatic logic [127:0] rand_blk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic start_test();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.en = 1'b1; bus.rx = 8'd0; bus.shakehand = 1'b1; bus.full = 1'b0;
        rst_n = 1'b0;
        idle(3);
        total++; if (bus.data !== 128'd0) $display("FAIL reset_data: got %h want 0", bus.data); else passed++;
        total++; if (bus.push !== 1'b0) $display("FAIL reset_push: got %b want 0", bus.push); else passed++;
        total++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.overflow); else passed++;
        total++; if (bus.timeout_err !== 1'b0) $display("FAIL reset_timeout: got %b want 0", bus.timeout_err); else passed++;
        rst_n = 1'b1;
        idle(4);
        total++; if (obs_q.size() !== 0) $display("FAIL reset_quiet: got %0d events want 0", obs_q.size()); else passed++;
    endtask

    task automatic test_single();
        start_test();
        send_block(128'h00112233445566778899AABBCCDDEEFF, 2, 2, 1'b0);
        idle(LAT + 4);
        total++; if (bus.data !== 128'h00112233445566778899AABBCCDDEEFF) $display("FAIL single_data: got %h want 00112233445566778899aabbccddeeff", bus.data); else passed++;
        total++; if (obs_q.size() !== exp_q.size()) $display("FAIL single_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = mk_ev(3, -1, 128'd0);
            if (i < obs_q.size()) o = obs_q[i];
            total++;
            if (o.kind !== exp_q[i].kind || o.st !== exp_q[i].st || o.d !== exp_q[i].d)
                $display("FAIL single_ev%0d: got kind %0d @%0d %h want kind %0d @%0d %h", i, o.kind, o.st, o.d, exp_q[i].kind, exp_q[i].st, exp_q[i].d);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        start_test();
        for (int i = 0; i < 16; i++) send_byte(8'hA5, 1);
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1);
        idle(LAT + 4);
        total++; if (bus.data !== 128'h000102030405060708090A0B0C0D0E0F) $display("FAIL b2b_hold: got %h want 000102030405060708090a0b0c0d0e0f", bus.data); else passed++;
        total++; if (obs_q.size() !== exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = mk_ev(3, -1, 128'd0);
            if (i < obs_q.size()) o = obs_q[i];
            total++;
            if (o.kind !== exp_q[i].kind || o.st !== exp_q[i].st || o.d !== exp_q[i].d)
                $display("FAIL b2b_ev%0d: got kind %0d @%0d %h want kind %0d @%0d %h", i, o.kind, o.st, o.d, exp_q[i].kind, exp_q[i].st, exp_q[i].d);
            else passed++;
        end
    endtask

    task automatic test_overflow();
        logic [127:0] prev;
        start_test();
        prev = m_data;
        send_block(rand_blk(), 1, 3, 1'b1);
        idle(2);
        total++; if (bus.data !== prev) $display("FAIL ovf_data_kept: got %h want %h", bus.data, prev); else passed++;
        send_block(rand_blk(), 1, 3, 1'b0);
        idle(LAT + 4);
        total++; if (obs_q.size() !== exp_q.size()) $display("FAIL ovf_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = mk_ev(3, -1, 128'd0);
            if (i < obs_q.size()) o = obs_q[i];
            total++;
            if (o.kind !== exp_q[i].kind || o.st !== exp_q[i].st || o.d !== exp_q[i].d)
                $display("FAIL ovf_ev%0d: got kind %0d @%0d %h want kind %0d @%0d %h", i, o.kind, o.st, o.d, exp_q[i].kind, exp_q[i].st, exp_q[i].d);
            else passed++;
        end
    endtask

    task automatic test_timeout();
        start_test();
        for (int i = 0; i < 5; i++) send_byte(8'($urandom()), 1);
        idle(70);
        send_block(rand_blk(), 1, 2, 1'b0);
        idle(LAT + 4);
        total++; if (obs_q.size() !== exp_q.size()) $display("FAIL timeout_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = mk_ev(3, -1, 128'd0);
            if (i < obs_q.size()) o = obs_q[i];
            total++;
            if (o.kind !== exp_q[i].kind || o.st !== exp_q[i].st || o.d !== exp_q[i].d)
                $display("FAIL timeout_ev%0d: got kind %0d @%0d %h want kind %0d @%0d %h", i, o.kind, o.st, o.d, exp_q[i].kind, exp_q[i].st, exp_q[i].d);
            else passed++;
        end
    endtask

    task automatic test_edge_at_deadline();
        logic [127:0] blk;
        start_test();
        blk = rand_blk();
        for (int i = 0; i < 16; i++) send_byte(blk[127-8*i -: 8], (i == 4) ? TMO : 1);
        idle(LAT + 4);
        total++; if (bus.data !== blk) $display("FAIL deadline_data: got %h want %h", bus.data, blk); else passed++;
        total++; if (obs_q.size() !== exp_q.size()) $display("FAIL deadline_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = mk_ev(3, -1, 128'd0);
            if (i < obs_q.size()) o = obs_q[i];
            total++;
            if (o.kind !== exp_q[i].kind || o.st !== exp_q[i].st || o.d !== exp_q[i].d)
                $display("FAIL deadline_ev%0d: got kind %0d @%0d %h want kind %0d @%0d %h", i, o.kind, o.st, o.d, exp_q[i].kind, exp_q[i].st, exp_q[i].d);
            else passed++;
        end
    endtask

    task automatic test_reset_mid_block();
        start_test();
        for (int i = 0; i < 7; i++) send_byte(8'($urandom()), 1);
        idle(LAT + 2);
        rst_n = 1'b0;
        bus.shakehand = 1'b1;
        mq.delete();
        m_data = 128'd0;
        idle(2);
        total++; if ({bus.push, bus.overflow, bus.timeout_err} !== 3'b000) $display("FAIL rstmid_pulses: got %b want 000", {bus.push, bus.overflow, bus.timeout_err}); else passed++;
        total++; if (bus.data !== 128'd0) $display("FAIL rstmid_data: got %h want 0", bus.data); else passed++;
        rst_n = 1'b1;
        idle(3);
        send_block(rand_blk(), 1, 2, 1'b0);
        idle(LAT + 4);
        total++; if (obs_q.size() !== exp_q.size()) $display("FAIL rstmid_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = mk_ev(3, -1, 128'd0);
            if (i < obs_q.size()) o = obs_q[i];
            total++;
            if (o.kind !== exp_q[i].kind || o.st !== exp_q[i].st || o.d !== exp_q[i].d)
                $display("FAIL rstmid_ev%0d: got kind %0d @%0d %h want kind %0d @%0d %h", i, o.kind, o.st, o.d, exp_q[i].kind, exp_q[i].st, exp_q[i].d);
            else passed++;
        end
    endtask

    task automatic test_en_mid_block();
        logic [127:0] prev;
        start_test();
        prev = m_data;
        for (int i = 0; i < 7; i++) send_byte(8'($urandom()), 1);
        idle(LAT + 2);
        bus.en = 1'b0;
        mq.delete();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.rx        = 8'($urandom());
            bus.shakehand = ~bus.shakehand;
        end
        @(negedge clk);
        bus.shakehand = 1'b1;
        idle(LAT + 3);
        total++; if ({bus.push, bus.overflow, bus.timeout_err} !== 3'b000) $display("FAIL enmid_pulses: got %b want 000", {bus.push, bus.overflow, bus.timeout_err}); else passed++;
        total++; if (bus.data !== prev) $display("FAIL enmid_data: got %h want %h", bus.data, prev); else passed++;
        bus.en = 1'b1;
        idle(3);
        send_block(rand_blk(), 1, 2, 1'b0);
        idle(LAT + 4);
        total++; if (obs_q.size() !== exp_q.size()) $display("FAIL enmid_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = mk_ev(3, -1, 128'd0);
            if (i < obs_q.size()) o = obs_q[i];
            total++;
            if (o.kind !== exp_q[i].kind || o.st !== exp_q[i].st || o.d !== exp_q[i].d)
                $display("FAIL enmid_ev%0d: got kind %0d @%0d %h want kind %0d @%0d %h", i, o.kind, o.st, o.d, exp_q[i].kind, exp_q[i].st, exp_q[i].d);
            else passed++;
        end
    endtask

    task automatic test_random_traffic();
        start_test();
        for (int n = 0; n < 6; n++) send_block(rand_blk(), 1, 3, ($urandom_range(3, 0) == 0));
        idle(LAT + 4);
        total++; if (bus.data !== m_data) $display("FAIL random_hold: got %h want %h", bus.data, m_data); else passed++;
        total++; if (obs_q.size() !== exp_q.size()) $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            ev_t o;
            o = mk_ev(3, -1, 128'd0);
            if (i < obs_q.size()) o = obs_q[i];
            total++;
            if (o.kind !== exp_q[i].kind || o.st !== exp_q[i].st || o.d !== exp_q[i].d)
                $display("FAIL random_ev%0d: got kind %0d @%0d %h want kind %0d @%0d %h", i, o.kind, o.st, o.d, exp_q[i].kind, exp_q[i].st, exp_q[i].d);
            else passed++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_edge_at_deadline();
        test_reset_mid_block();
        test_en_mid_block();
        test_random_traffic();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
